// File: rtl/agu_pipelined.sv
// Two-stage pipelined address generator (base+imm, base-imm, base + idx<<scale) with writeback backpressure.
// Define AGU_ALIGN_CHECK_EN to raise a misalignment exception and suppress the PRF write of misaligned results.

package agu_pkg;
  localparam int OP_W  = 4;
  localparam int REG_W = 6;
  localparam int IMM_W = 16;
  localparam int ROB_W = 4;

  localparam logic [OP_W-1:0] UOP_AGU_ADD = 4'h1;
  localparam logic [OP_W-1:0] UOP_AGU_SUB = 4'h2;
  localparam logic [OP_W-1:0] UOP_AGU_IDX = 4'h3;

  typedef struct packed {
    logic [OP_W-1:0]  operation;
    logic [REG_W-1:0] operand_a;
    logic [REG_W-1:0] operand_b;
    logic [IMM_W-1:0] operand_c;
    logic [ROB_W-1:0] rob_ptr;
  } micro_op_t;
endpackage

`ifndef UOP_AGU_ADD
`define UOP_AGU_ADD agu_pkg::UOP_AGU_ADD
`endif
`ifndef UOP_AGU_SUB
`define UOP_AGU_SUB agu_pkg::UOP_AGU_SUB
`endif
`ifndef UOP_AGU_IDX
`define UOP_AGU_IDX agu_pkg::UOP_AGU_IDX
`endif

module agu_pipelined
  import agu_pkg::*;
#(
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int ROB_LEN           = 16,
  parameter int DATA_W            = 32,
  parameter int ALIGN_LOG2        = 2,
  localparam int RW = $clog2(NUM_PHYSICAL_REGS),
  localparam int PW = $clog2(ROB_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_uop_p,
  input  micro_op_t         i_uop,
  output logic              o_stall,
  output logic [RW-1:0]     o_rf_rd_trgt_a,
  input  logic [DATA_W-1:0] i_rf_rd_dat_a,
  output logic [RW-1:0]     o_rf_rd_trgt_b,
  input  logic [DATA_W-1:0] i_rf_rd_dat_b,
  output logic              o_wb_req,
  input  logic              i_wb_gnt,
  output logic [RW-1:0]     o_rf_wr_trgt,
  output logic [DATA_W-1:0] o_rf_wr_dat,
  output logic              o_rf_we,
  output logic              o_uop_dn,
  output logic [PW-1:0]     o_uop_ptr,
  output logic              o_uop_exc
);

  logic              s1_v;
  logic [OP_W-1:0]   s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [DATA_W-1:0] s1_imm;
  logic [RW-1:0]     s1_dst;
  logic [PW-1:0]     s1_ptr;

  logic              s2_v;
  logic [DATA_W-1:0] s2_res;
  logic [RW-1:0]     s2_dst;
  logic [PW-1:0]     s2_ptr;
  logic              s2_exc;

  logic              accept;
  logic              s1_move;
  logic              s2_fire;
  logic [DATA_W-1:0] s1_res;
  logic [1:0]        s1_scale;
  logic signed [IMM_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_ext;

  assign o_rf_rd_trgt_a = i_uop.operand_a[RW-1:0];
  assign o_rf_rd_trgt_b = i_uop.operand_c[RW-1:0];

  assign imm_s   = i_uop.operand_c;
  assign imm_ext = DATA_W'(imm_s);

  // Handshakes are gated by i_rst so nothing is accepted or retired while reset is held.
  assign o_wb_req = s2_v & ~i_rst;
  assign s2_fire  = o_wb_req & i_wb_gnt;
  assign s1_move  = s1_v & (~s2_v | s2_fire) & ~i_rst;
  assign o_stall  = s1_v & s2_v & ~i_wb_gnt & ~i_rst;
  assign accept   = i_uop_p & ~o_stall & ~i_rst;

  assign s1_scale = s1_imm[9:8];

  // NOTE: assign a default at the top of every always_comb so no path leaves the output unassigned (no latch).
  always_comb begin
    s1_res = s1_a;
    case (s1_op)
      `UOP_AGU_ADD: s1_res = s1_a + s1_imm;
      `UOP_AGU_SUB: s1_res = s1_a - s1_imm;
      `UOP_AGU_IDX: s1_res = s1_a + (s1_b << s1_scale);
      default:      s1_res = s1_a;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; only the valid bits need reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (accept)       s1_v <= 1'b1;
      else if (s1_move) s1_v <= 1'b0;

      if (s1_move)      s2_v <= 1'b1;
      else if (s2_fire) s2_v <= 1'b0;
    end
  end

  // NOTE: datapath registers carry no reset; their contents are qualified by the valid bits.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      s1_op  <= i_uop.operation;
      s1_a   <= i_rf_rd_dat_a;
      s1_b   <= i_rf_rd_dat_b;
      s1_imm <= imm_ext;
      s1_dst <= i_uop.operand_b[RW-1:0];
      s1_ptr <= i_uop.rob_ptr[PW-1:0];
    end
    if (s1_move) begin
      s2_res <= s1_res;
      s2_dst <= s1_dst;
      s2_ptr <= s1_ptr;
    end
  end

`ifdef AGU_ALIGN_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (s1_move) s2_exc <= |s1_res[ALIGN_LOG2-1:0];
  end
`else
  assign s2_exc = 1'b0;
`endif

  // S2 registers only reload when S2 empties, so these stay put while waiting for grant.
  assign o_rf_wr_trgt = s2_dst;
  assign o_rf_wr_dat  = s2_res;
  assign o_uop_ptr    = s2_ptr;
  assign o_uop_dn     = s2_fire;
  assign o_rf_we      = s2_fire & ~s2_exc;
  assign o_uop_exc    = s2_fire & s2_exc;

endmodule
